// File: rtl/segre_history_buffer.sv
// rtl/segre_history_buffer.sv - in-order history buffer with completion tracking, retire and exception rollback
// Saves old destination values at issue so an exception at the head can restore the register file newest-first.
module segre_history_buffer #(
  parameter  int HB_DEPTH = 8,
  parameter  int N_CMPL   = 4,
  parameter  int REG_W    = 5,
  parameter  int DATA_W   = 32,
  parameter  int ADDR_W   = 32,
  localparam int PTR_W    = $clog2(HB_DEPTH)
) (
  input  logic                      clk_i,
  input  logic                      rsn_i,
  input  logic                      alloc_valid_i,
  input  logic                      alloc_store_i,
  input  logic [REG_W-1:0]          alloc_dest_reg_i,
  input  logic [DATA_W-1:0]         alloc_value_i,
  input  logic [ADDR_W-1:0]         alloc_pc_i,
  output logic                      alloc_ready_o,
  output logic [PTR_W-1:0]          alloc_id_o,
  input  logic [N_CMPL-1:0]         cmpl_valid_i,
  input  logic [N_CMPL*PTR_W-1:0]   cmpl_id_i,
  input  logic                      exc_valid_i,
  input  logic [PTR_W-1:0]          exc_id_i,
  output logic [PTR_W:0]            count_o,
  output logic                      full_o,
  output logic                      empty_o,
  output logic                      store_permission_o,
  output logic                      retire_valid_o,
  output logic [PTR_W-1:0]          retire_id_o,
  output logic                      recovering_o,
  output logic                      rb_valid_o,
  output logic [REG_W-1:0]          rb_dest_reg_o,
  output logic [DATA_W-1:0]         rb_value_o,
  output logic [ADDR_W-1:0]         rb_pc_o,
  output logic                      exc_done_o,
  output logic [ADDR_W-1:0]         exc_pc_o
);

  typedef enum logic [2:0] {
    HB_EMPTY   = 3'd0,
    HB_EXEC    = 3'd1,
    HB_EXEC_ST = 3'd2,
    HB_DONE    = 3'd3,
    HB_EXC     = 3'd4
  } hb_status_e;

  typedef enum logic {
    ST_NORMAL     = 1'b0,
    ST_RECOVERING = 1'b1
  } hb_state_e;

  localparam logic [PTR_W:0]   CNT_ONE   = {{PTR_W{1'b0}}, 1'b1};
  localparam logic [PTR_W-1:0] PTR_ONE   = {{(PTR_W-1){1'b0}}, 1'b1};
  localparam logic [PTR_W:0]   CNT_DEPTH = (PTR_W+1)'(HB_DEPTH);

  hb_status_e        status_q [HB_DEPTH];
  hb_status_e        status_d [HB_DEPTH];
  logic [REG_W-1:0]  dest_q   [HB_DEPTH];
  logic [REG_W-1:0]  dest_d   [HB_DEPTH];
  logic [DATA_W-1:0] value_q  [HB_DEPTH];
  logic [DATA_W-1:0] value_d  [HB_DEPTH];
  logic [ADDR_W-1:0] pc_q     [HB_DEPTH];
  logic [ADDR_W-1:0] pc_d     [HB_DEPTH];

  logic [PTR_W-1:0]  head_q, head_d;
  logic [PTR_W-1:0]  tail_q, tail_d;
  logic [PTR_W:0]    count_q, count_d;
  hb_state_e         state_q, state_d;
  logic [ADDR_W-1:0] exc_pc_q, exc_pc_d;

  logic              full;
  logic              alloc_fire;
  logic              retire_fire;
  logic              head_busy;
  logic              head_exc;
  logic [PTR_W-1:0]  tail_m1;
  hb_status_e        head_status;

  assign full        = (count_q == CNT_DEPTH);
  assign head_status = status_q[head_q];
  assign tail_m1     = tail_q - PTR_ONE;
  assign head_busy   = (head_status == HB_EXEC) || (head_status == HB_EXEC_ST);
  assign alloc_fire  = alloc_valid_i && alloc_ready_o;
  assign retire_fire = retire_valid_o;

  // An exception arriving on a busy head enters recovery at the same edge,
  // so rollback starts one cycle after the report instead of two.
  assign head_exc = (head_status == HB_EXC) ||
                    (exc_valid_i && (exc_id_i == head_q) && head_busy);

  assign alloc_ready_o      = (state_q == ST_NORMAL) && !full;
  assign alloc_id_o         = tail_q;
  assign count_o            = count_q;
  assign full_o             = full;
  assign empty_o            = (count_q == '0);
  assign store_permission_o = (state_q == ST_NORMAL) && (head_status == HB_EXEC_ST);
  assign retire_valid_o     = (state_q == ST_NORMAL) && (head_status == HB_DONE);
  assign retire_id_o        = head_q;
  assign recovering_o       = (state_q == ST_RECOVERING);
  assign rb_valid_o         = (state_q == ST_RECOVERING) && (count_q != '0);
  assign rb_dest_reg_o      = dest_q[tail_m1];
  assign rb_value_o         = value_q[tail_m1];
  assign rb_pc_o            = pc_q[tail_m1];
  assign exc_done_o         = (state_q == ST_RECOVERING) && (count_q == '0);
  assign exc_pc_o           = exc_pc_q;

  always_comb begin
    logic [PTR_W-1:0] cid;
    status_d = status_q;
    dest_d   = dest_q;
    value_d  = value_q;
    pc_d     = pc_q;
    head_d   = head_q;
    tail_d   = tail_q;
    count_d  = count_q;
    state_d  = state_q;
    exc_pc_d = exc_pc_q;
    cid      = '0;

    case (state_q)
      ST_NORMAL: begin
        for (int k = 0; k < N_CMPL; k++) begin
          cid = cmpl_id_i[k*PTR_W +: PTR_W];
          if (cmpl_valid_i[k] &&
              ((status_q[cid] == HB_EXEC) || (status_q[cid] == HB_EXEC_ST))) begin
            status_d[cid] = HB_DONE;
          end
        end

        // Applied after completions so it overrides one to the same id.
        if (exc_valid_i &&
            ((status_q[exc_id_i] == HB_EXEC) || (status_q[exc_id_i] == HB_EXEC_ST))) begin
          status_d[exc_id_i] = HB_EXC;
        end

        if (retire_fire) begin
          status_d[head_q] = HB_EMPTY;
          head_d           = head_q + PTR_ONE;
        end

        if (alloc_fire) begin
          status_d[tail_q] = alloc_store_i ? HB_EXEC_ST : HB_EXEC;
          dest_d[tail_q]   = alloc_dest_reg_i;
          value_d[tail_q]  = alloc_value_i;
          pc_d[tail_q]     = alloc_pc_i;
          tail_d           = tail_q + PTR_ONE;
        end

        if (alloc_fire && !retire_fire) begin
          count_d = count_q + CNT_ONE;
        end else if (!alloc_fire && retire_fire) begin
          count_d = count_q - CNT_ONE;
        end

        if (head_exc) begin
          state_d  = ST_RECOVERING;
          exc_pc_d = pc_q[head_q];
        end
      end

      ST_RECOVERING: begin
        if (count_q != '0) begin
          status_d[tail_m1] = HB_EMPTY;
          tail_d            = tail_m1;
          count_d           = count_q - CNT_ONE;
        end else begin
          state_d = ST_NORMAL;
        end
      end

      default: state_d = ST_NORMAL;
    endcase
  end

  always_ff @(posedge clk_i or negedge rsn_i) begin
    if (!rsn_i) begin
      for (int i = 0; i < HB_DEPTH; i++) begin
        status_q[i] <= HB_EMPTY;
        dest_q[i]   <= '0;
        value_q[i]  <= '0;
        pc_q[i]     <= '0;
      end
      head_q   <= '0;
      tail_q   <= '0;
      count_q  <= '0;
      state_q  <= ST_NORMAL;
      exc_pc_q <= '0;
    end else begin
      status_q <= status_d;
      dest_q   <= dest_d;
      value_q  <= value_d;
      pc_q     <= pc_d;
      head_q   <= head_d;
      tail_q   <= tail_d;
      count_q  <= count_d;
      state_q  <= state_d;
      exc_pc_q <= exc_pc_d;
    end
  end

endmodule

// File: tb/tb_segre_history_buffer.sv
// tb/tb_segre_history_buffer.sv - directed self-checking bench for segre_history_buffer
module tb_segre_history_buffer;

  localparam int DEPTH = 8;
  localparam int NC    = 4;
  localparam int PW    = 3;

  logic          clk = 1'b0;
  logic          rsn_i;
  logic          alloc_valid_i;
  logic          alloc_store_i;
  logic [4:0]    alloc_dest_reg_i;
  logic [31:0]   alloc_value_i;
  logic [31:0]   alloc_pc_i;
  logic          alloc_ready_o;
  logic [PW-1:0] alloc_id_o;
  logic [NC-1:0] cmpl_valid_i;
  logic [NC*PW-1:0] cmpl_id_i;
  logic          exc_valid_i;
  logic [PW-1:0] exc_id_i;
  logic [PW:0]   count_o;
  logic          full_o, empty_o, store_permission_o;
  logic          retire_valid_o;
  logic [PW-1:0] retire_id_o;
  logic          recovering_o, rb_valid_o;
  logic [4:0]    rb_dest_reg_o;
  logic [31:0]   rb_value_o, rb_pc_o;
  logic          exc_done_o;
  logic [31:0]   exc_pc_o;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  segre_history_buffer #(
    .HB_DEPTH(DEPTH), .N_CMPL(NC), .REG_W(5), .DATA_W(32), .ADDR_W(32)
  ) dut (
    .clk_i(clk), .rsn_i(rsn_i),
    .alloc_valid_i(alloc_valid_i), .alloc_store_i(alloc_store_i),
    .alloc_dest_reg_i(alloc_dest_reg_i), .alloc_value_i(alloc_value_i),
    .alloc_pc_i(alloc_pc_i), .alloc_ready_o(alloc_ready_o), .alloc_id_o(alloc_id_o),
    .cmpl_valid_i(cmpl_valid_i), .cmpl_id_i(cmpl_id_i),
    .exc_valid_i(exc_valid_i), .exc_id_i(exc_id_i),
    .count_o(count_o), .full_o(full_o), .empty_o(empty_o),
    .store_permission_o(store_permission_o),
    .retire_valid_o(retire_valid_o), .retire_id_o(retire_id_o),
    .recovering_o(recovering_o), .rb_valid_o(rb_valid_o),
    .rb_dest_reg_o(rb_dest_reg_o), .rb_value_o(rb_value_o), .rb_pc_o(rb_pc_o),
    .exc_done_o(exc_done_o), .exc_pc_o(exc_pc_o)
  );

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic clear_inputs();
    alloc_valid_i    = 1'b0;
    alloc_store_i    = 1'b0;
    alloc_dest_reg_i = '0;
    alloc_value_i    = '0;
    alloc_pc_i       = '0;
    cmpl_valid_i     = '0;
    cmpl_id_i        = '0;
    exc_valid_i      = 1'b0;
    exc_id_i         = '0;
  endtask

  task automatic set_alloc(input logic st, input logic [4:0] rd, input logic [31:0] val,
                           input logic [31:0] pc);
    alloc_valid_i    = 1'b1;
    alloc_store_i    = st;
    alloc_dest_reg_i = rd;
    alloc_value_i    = val;
    alloc_pc_i       = pc;
  endtask

  task automatic set_cmpl(input int ch, input logic [PW-1:0] id);
    cmpl_valid_i[ch]       = 1'b1;
    cmpl_id_i[ch*PW +: PW] = id;
  endtask

  task automatic do_reset();
    clear_inputs();
    rsn_i = 1'b0;
    tick();
    rsn_i = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    clear_inputs();
    rsn_i = 1'b0;
    tick();
    checks++; if (count_o !== 4'd0) begin errors++; $display("FAIL reset_count got %0d exp 0", count_o); end
    checks++; if (empty_o !== 1'b1 || full_o !== 1'b0) begin errors++; $display("FAIL reset_flags got empty=%0b full=%0b exp 1/0", empty_o, full_o); end
    checks++; if (alloc_ready_o !== 1'b1 || alloc_id_o !== 3'd0) begin errors++; $display("FAIL reset_alloc got rdy=%0b id=%0d exp 1/0", alloc_ready_o, alloc_id_o); end
    checks++; if (recovering_o !== 1'b0 || retire_valid_o !== 1'b0 || store_permission_o !== 1'b0 || rb_valid_o !== 1'b0 || exc_done_o !== 1'b0) begin errors++; $display("FAIL reset_ctrl got rec=%0b ret=%0b sp=%0b rb=%0b done=%0b exp 0", recovering_o, retire_valid_o, store_permission_o, rb_valid_o, exc_done_o); end
    checks++; if (exc_pc_o !== 32'h0) begin errors++; $display("FAIL reset_exc_pc got %0h exp 0", exc_pc_o); end
    rsn_i = 1'b1;
    tick();
  endtask

  task automatic test_fill_drain();
    do_reset();
    for (int i = 0; i < 8; i++) begin
      checks++; if (alloc_ready_o !== 1'b1 || alloc_id_o !== 3'(i)) begin errors++; $display("FAIL fill_alloc_id got rdy=%0b id=%0d exp 1/%0d", alloc_ready_o, alloc_id_o, i); end
      set_alloc(1'b0, 5'(i + 1), 32'h1000 + 32'(i), 32'h40 + 32'(4 * i));
      tick();
    end
    checks++; if (full_o !== 1'b1 || alloc_ready_o !== 1'b0 || count_o !== 4'd8) begin errors++; $display("FAIL fill_full got full=%0b rdy=%0b cnt=%0d exp 1/0/8", full_o, alloc_ready_o, count_o); end
    tick();
    clear_inputs();
    checks++; if (count_o !== 4'd8 || alloc_id_o !== 3'd0 || full_o !== 1'b1) begin errors++; $display("FAIL fill_drop got cnt=%0d id=%0d full=%0b exp 8/0/1", count_o, alloc_id_o, full_o); end
    for (int i = 0; i < 8; i++) begin
      cmpl_valid_i = '0;
      set_cmpl(2, 3'(i));
      tick();
      checks++; if (retire_valid_o !== 1'b1 || retire_id_o !== 3'(i)) begin errors++; $display("FAIL drain_retire got v=%0b id=%0d exp 1/%0d", retire_valid_o, retire_id_o, i); end
    end
    clear_inputs();
    tick();
    checks++; if (empty_o !== 1'b1 || count_o !== 4'd0 || retire_valid_o !== 1'b0) begin errors++; $display("FAIL drain_empty got empty=%0b cnt=%0d ret=%0b exp 1/0/0", empty_o, count_o, retire_valid_o); end
  endtask

  task automatic test_out_of_order();
    do_reset();
    for (int i = 0; i < 4; i++) begin
      set_alloc(1'b0, 5'(i), 32'(i), 32'(i));
      tick();
    end
    clear_inputs();
    set_cmpl(0, 3'd3);
    tick();
    checks++; if (retire_valid_o !== 1'b0) begin errors++; $display("FAIL ooo_hold3 got %0b exp 0", retire_valid_o); end
    clear_inputs();
    set_cmpl(1, 3'd1);
    set_cmpl(3, 3'd1);
    tick();
    checks++; if (retire_valid_o !== 1'b0) begin errors++; $display("FAIL ooo_hold1 got %0b exp 0", retire_valid_o); end
    clear_inputs();
    set_cmpl(3, 3'd2);
    tick();
    checks++; if (retire_valid_o !== 1'b0 || count_o !== 4'd4) begin errors++; $display("FAIL ooo_hold2 got ret=%0b cnt=%0d exp 0/4", retire_valid_o, count_o); end
    clear_inputs();
    set_cmpl(0, 3'd0);
    tick();
    clear_inputs();
    for (int i = 0; i < 4; i++) begin
      checks++; if (retire_valid_o !== 1'b1 || retire_id_o !== 3'(i)) begin errors++; $display("FAIL ooo_retire got v=%0b id=%0d exp 1/%0d", retire_valid_o, retire_id_o, i); end
      tick();
    end
    checks++; if (empty_o !== 1'b1) begin errors++; $display("FAIL ooo_empty got %0b exp 1", empty_o); end
  endtask

  task automatic test_wrap();
    logic [PW-1:0] t;
    do_reset();
    for (int i = 0; i < 6; i++) begin
      set_alloc(1'b0, 5'd1, 32'(i), 32'(i));
      tick();
    end
    clear_inputs();
    for (int i = 0; i < 6; i++) begin
      cmpl_valid_i = '0;
      set_cmpl(1, 3'(i));
      tick();
    end
    clear_inputs();
    tick();
    checks++; if (count_o !== 4'd0 || alloc_id_o !== 3'd6) begin errors++; $display("FAIL wrap_setup got cnt=%0d id=%0d exp 0/6", count_o, alloc_id_o); end
    set_alloc(1'b0, 5'd2, 32'h6, 32'h6);
    tick();
    set_alloc(1'b0, 5'd2, 32'h7, 32'h7);
    set_cmpl(0, 3'd6);
    tick();
    t = 3'd0;
    for (int j = 0; j < 10; j++) begin
      checks++; if (alloc_id_o !== t || count_o !== 4'd2 || retire_valid_o !== 1'b1 || retire_id_o !== 3'(t - 3'd2)) begin
        errors++; $display("FAIL wrap_step got id=%0d cnt=%0d ret=%0b rid=%0d exp %0d/2/1/%0d", alloc_id_o, count_o, retire_valid_o, retire_id_o, t, 3'(t - 3'd2));
      end
      clear_inputs();
      set_alloc(1'b0, 5'd3, 32'(j), 32'(j));
      set_cmpl(0, 3'(t - 3'd1));
      tick();
      t = t + 3'd1;
    end
    clear_inputs();
  endtask

  task automatic test_store();
    do_reset();
    set_alloc(1'b1, 5'd0, 32'h55, 32'h300);
    tick();
    clear_inputs();
    checks++; if (store_permission_o !== 1'b1 || retire_valid_o !== 1'b0) begin errors++; $display("FAIL store_perm got sp=%0b ret=%0b exp 1/0", store_permission_o, retire_valid_o); end
    set_cmpl(1, 3'd0);
    tick();
    clear_inputs();
    checks++; if (store_permission_o !== 1'b0 || retire_valid_o !== 1'b1 || retire_id_o !== 3'd0) begin errors++; $display("FAIL store_done got sp=%0b ret=%0b id=%0d exp 0/1/0", store_permission_o, retire_valid_o, retire_id_o); end
    tick();
    checks++; if (empty_o !== 1'b1) begin errors++; $display("FAIL store_empty got %0b exp 1", empty_o); end
  endtask

  task automatic test_exception();
    do_reset();
    for (int i = 0; i < 5; i++) begin
      set_alloc(1'b0, 5'(i + 1), 32'hA000 + 32'(i), 32'h100 + 32'(4 * i));
      tick();
    end
    clear_inputs();
    checks++; if (count_o !== 4'd5) begin errors++; $display("FAIL exc_count got %0d exp 5", count_o); end
    exc_valid_i = 1'b1;
    exc_id_i    = 3'd0;
    tick();
    clear_inputs();
    checks++; if (recovering_o !== 1'b1 || alloc_ready_o !== 1'b0) begin errors++; $display("FAIL exc_enter got rec=%0b rdy=%0b exp 1/0", recovering_o, alloc_ready_o); end
    for (int k = 0; k < 5; k++) begin
      checks++; if (rb_valid_o !== 1'b1 || exc_done_o !== 1'b0 || rb_pc_o !== 32'h110 - 32'(4 * k) ||
                    rb_value_o !== 32'hA004 - 32'(k) || rb_dest_reg_o !== 5'(5 - k)) begin
        errors++; $display("FAIL exc_rollback got v=%0b done=%0b pc=%0h val=%0h rd=%0d exp 1/0/%0h/%0h/%0d", rb_valid_o, exc_done_o, rb_pc_o, rb_value_o, rb_dest_reg_o, 32'h110 - 32'(4 * k), 32'hA004 - 32'(k), 5 - k);
      end
      tick();
    end
    checks++; if (exc_done_o !== 1'b1 || exc_pc_o !== 32'h100 || rb_valid_o !== 1'b0 || count_o !== 4'd0) begin errors++; $display("FAIL exc_done got done=%0b pc=%0h rb=%0b cnt=%0d exp 1/100/0/0", exc_done_o, exc_pc_o, rb_valid_o, count_o); end
    tick();
    checks++; if (recovering_o !== 1'b0 || alloc_ready_o !== 1'b1 || exc_done_o !== 1'b0 || count_o !== 4'd0 || exc_pc_o !== 32'h100) begin errors++; $display("FAIL exc_exit got rec=%0b rdy=%0b done=%0b cnt=%0d pc=%0h exp 0/1/0/0/100", recovering_o, alloc_ready_o, exc_done_o, count_o, exc_pc_o); end
  endtask

  task automatic test_collision_reset();
    do_reset();
    for (int i = 0; i < 3; i++) begin
      set_alloc(1'b0, 5'(i + 8), 32'hB000 + 32'(i), 32'h200 + 32'(4 * i));
      tick();
    end
    clear_inputs();
    set_cmpl(0, 3'd1);
    exc_valid_i = 1'b1;
    exc_id_i    = 3'd1;
    tick();
    clear_inputs();
    checks++; if (retire_valid_o !== 1'b0 || recovering_o !== 1'b0) begin errors++; $display("FAIL coll_hold got ret=%0b rec=%0b exp 0/0", retire_valid_o, recovering_o); end
    set_cmpl(3, 3'd0);
    tick();
    clear_inputs();
    checks++; if (retire_valid_o !== 1'b1 || retire_id_o !== 3'd0) begin errors++; $display("FAIL coll_retire0 got v=%0b id=%0d exp 1/0", retire_valid_o, retire_id_o); end
    tick();
    checks++; if (retire_valid_o !== 1'b0 || recovering_o !== 1'b0 || count_o !== 4'd2) begin errors++; $display("FAIL coll_exc_head got ret=%0b rec=%0b cnt=%0d exp 0/0/2", retire_valid_o, recovering_o, count_o); end
    tick();
    checks++; if (recovering_o !== 1'b1 || rb_valid_o !== 1'b1 || rb_pc_o !== 32'h208) begin errors++; $display("FAIL coll_rb_first got rec=%0b rb=%0b pc=%0h exp 1/1/208", recovering_o, rb_valid_o, rb_pc_o); end
    tick();
    checks++; if (rb_pc_o !== 32'h204 || count_o !== 4'd1) begin errors++; $display("FAIL coll_rb_second got pc=%0h cnt=%0d exp 204/1", rb_pc_o, count_o); end
    rsn_i = 1'b0;
    #1;
    checks++; if (recovering_o !== 1'b0 || count_o !== 4'd0 || exc_done_o !== 1'b0 || rb_valid_o !== 1'b0 || exc_pc_o !== 32'h0) begin errors++; $display("FAIL mid_reset got rec=%0b cnt=%0d done=%0b rb=%0b pc=%0h exp 0/0/0/0/0", recovering_o, count_o, exc_done_o, rb_valid_o, exc_pc_o); end
    tick();
    rsn_i = 1'b1;
    tick();
    checks++; if (alloc_ready_o !== 1'b1 || empty_o !== 1'b1 || exc_done_o !== 1'b0) begin errors++; $display("FAIL post_reset got rdy=%0b empty=%0b done=%0b exp 1/1/0", alloc_ready_o, empty_o, exc_done_o); end
  endtask

  initial begin
    clear_inputs();
    rsn_i = 1'b0;
    test_reset();
    test_fill_drain();
    test_out_of_order();
    test_wrap();
    test_store();
    test_exception();
    test_collision_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
